// File: rtl/product_accumulator_taint_track_word.sv
// Accumulates a counted run of multiplier products into a guard-extended sum and
// tracks word-level taint for the control path (sticky) and the data path (per run).
module product_accumulator_taint_track_word #(
  parameter int WIDTH = 64,
  parameter int GUARD = 8,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  // begin is a reserved word, so the launch request is begin_req
  input  logic                     begin_req,
  input  logic                     begin_t,
  input  logic [CW-1:0]            count,
  input  logic                     count_t,
  input  logic [2*WIDTH-1:0]       product,
  input  logic                     product_t,
  input  logic                     productDone,
  input  logic                     productDone_t,
  input  logic                     accAck,
  input  logic                     accAck_t,
  output logic [2*WIDTH+GUARD-1:0] acc,
  output logic                     acc_t,
  output logic                     accValid,
  output logic                     accValid_t,
  output logic                     overflow,
  output logic                     overflow_t,
  output logic                     busy
);

  localparam int AW = 2*WIDTH + GUARD;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] remaining;
  logic          done_q;
  logic          ctl_t, dat_t;
  logic          capture, launch, take;
  logic [AW:0]   sum;

  // Rising edge of the done level; a level held high counts once.
  assign capture = productDone & ~done_q;
  assign sum     = {1'b0, acc} + {{(GUARD+1){1'b0}}, product};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    launch    = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: if (begin_req) begin
        launch    = 1'b1;
        state_nxt = (count == '0) ? HOLD : WAIT;
      end
      WAIT: if (capture) begin
        take = 1'b1;
        if (remaining == CW'(1)) state_nxt = HOLD;
      end
      HOLD: if (accAck) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      overflow  <= 1'b0;
      remaining <= '0;
      done_q    <= 1'b0;
      ctl_t     <= 1'b0;
      dat_t     <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values.
      done_q <= productDone;
      if (launch) begin
        acc       <= '0;
        overflow  <= 1'b0;
        remaining <= count;
        dat_t     <= 1'b0;
      end else if (take) begin
        acc       <= sum[AW-1:0];
        overflow  <= overflow | sum[AW];
        remaining <= remaining - CW'(1);
        dat_t     <= dat_t | product_t;
      end
      // Control taint is sticky until reset: once steering was tainted, it stays so.
      ctl_t <= ctl_t
             | (launch & (begin_t | count_t))
             | ((state == WAIT) & productDone_t)
             | ((state == HOLD) & accAck_t);
    end
  end

  assign accValid   = (state == HOLD);
  assign busy       = (state != IDLE);
  assign acc_t      = dat_t | ctl_t;
  assign accValid_t = ctl_t;
  assign overflow_t = acc_t;

endmodule

// File: tb/tb_product_accumulator_taint_track_word.sv
// Drives a wide-guard and a narrow no-guard instance in parallel from shared inputs and
// compares both against a run-total model (sum of products, overflow = total beyond 2^AW).
module tb_product_accumulator_taint_track_word;

  localparam int BW = 16, BG = 4, BAW = 2*BW + BG;   // 36-bit accumulator
  localparam int SW = 4,  SG = 0, SAW = 2*SW + SG;   // 8-bit accumulator
  localparam longint unsigned BMOD = 64'd1 << BAW;
  localparam longint unsigned SMOD = 64'd1 << SAW;

  logic        clk = 1'b0;
  logic        rst;
  logic        begin_req, begin_t, count_t, product_t;
  logic        productDone, productDone_t, accAck, accAck_t;
  logic [7:0]  count;
  logic [31:0] product;

  logic [BAW-1:0] acc_b;
  logic [SAW-1:0] acc_s;
  logic acc_t_b, acc_valid_b, acc_valid_t_b, ovf_b, ovf_t_b, busy_b;
  logic acc_t_s, acc_valid_s, acc_valid_t_s, ovf_s, ovf_t_s, busy_s;

  longint unsigned exp_big, exp_small;
  bit              ctl_m, dat_m;
  int              total = 0;
  int              bad   = 0;

  always #5 clk = ~clk;

  product_accumulator_taint_track_word #(.WIDTH(BW), .GUARD(BG), .CW(8)) dut_big (
    .clk(clk), .rst(rst), .begin_req(begin_req), .begin_t(begin_t),
    .count(count), .count_t(count_t), .product(product), .product_t(product_t),
    .productDone(productDone), .productDone_t(productDone_t),
    .accAck(accAck), .accAck_t(accAck_t),
    .acc(acc_b), .acc_t(acc_t_b), .accValid(acc_valid_b), .accValid_t(acc_valid_t_b),
    .overflow(ovf_b), .overflow_t(ovf_t_b), .busy(busy_b)
  );

  product_accumulator_taint_track_word #(.WIDTH(SW), .GUARD(SG), .CW(8)) dut_small (
    .clk(clk), .rst(rst), .begin_req(begin_req), .begin_t(begin_t),
    .count(count), .count_t(count_t), .product(product[7:0]), .product_t(product_t),
    .productDone(productDone), .productDone_t(productDone_t),
    .accAck(accAck), .accAck_t(accAck_t),
    .acc(acc_s), .acc_t(acc_t_s), .accValid(acc_valid_s), .accValid_t(acc_valid_t_s),
    .overflow(ovf_s), .overflow_t(ovf_t_s), .busy(busy_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // NOTE: inputs change and outputs are sampled 1ns after the rising edge, never on it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input bit valid, input bit bsy);
    bit t;
    t = dat_m | ctl_m;
    check({tag, ":acc_big"},   acc_b,  exp_big % BMOD);
    check({tag, ":ovf_big"},   ovf_b,  exp_big >= BMOD);
    check({tag, ":acc_small"}, acc_s,  exp_small % SMOD);
    check({tag, ":ovf_small"}, ovf_s,  exp_small >= SMOD);
    check({tag, ":valid"},     {acc_valid_b, acc_valid_s}, {valid, valid});
    check({tag, ":busy"},      {busy_b, busy_s},           {bsy, bsy});
    check({tag, ":acc_t"},     {acc_t_b, acc_t_s},         {t, t});
    check({tag, ":valid_t"},   {acc_valid_t_b, acc_valid_t_s}, {ctl_m, ctl_m});
    check({tag, ":ovf_t"},     {ovf_t_b, ovf_t_s},         {t, t});
  endtask

  task automatic clear_inputs();
    begin_req = 0; begin_t = 0; count = 0; count_t = 0; product = 0; product_t = 0;
    productDone = 0; productDone_t = 0; accAck = 0; accAck_t = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    clear_inputs();
    #1;
    exp_big = 0; exp_small = 0; ctl_m = 0; dat_m = 0;
    check_all(tag, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic launch(input string tag, input logic [7:0] cnt, input bit bt, input bit ct);
    begin_req = 1; count = cnt; begin_t = bt; count_t = ct;
    tick();
    begin_req = 0; count = 0; begin_t = 0; count_t = 0;
    exp_big = 0; exp_small = 0; dat_m = 0; ctl_m |= bt | ct;
    check_all({tag, ":launch"}, cnt == 0, 1);
  endtask

  // One product: rising done edge, then done held for hold-1 extra cycles with junk data.
  task automatic feed(input string tag, input logic [31:0] p, input bit pt, input bit pdt,
                      input int hold, input bit last);
    product = p; product_t = pt; productDone = 1; productDone_t = pdt;
    tick();
    exp_big += p; exp_small += p & 32'hFF; dat_m |= pt; ctl_m |= pdt;
    product_t = 0; productDone_t = 0;
    check_all({tag, ":cap"}, last, 1);
    for (int i = 1; i < hold; i++) begin
      product = $urandom;
      tick();
    end
    productDone = 0;
    tick();
    check_all({tag, ":post"}, last, 1);
  endtask

  // HOLD stability against a tainted done pulse, then acknowledge (optionally with begin).
  task automatic finish_job(input string tag, input bit ack_t, input bit begin_too);
    productDone = 1; productDone_t = 1; product_t = 1; product = $urandom;
    tick();
    productDone = 0; productDone_t = 0; product_t = 0;
    tick();
    check_all({tag, ":hold"}, 1, 1);
    accAck = 1; accAck_t = ack_t; begin_req = begin_too; count = 8'd3;
    tick();
    ctl_m |= ack_t;
    clear_inputs();
    check_all({tag, ":ack"}, 0, 0);
    tick();
    check_all({tag, ":idle"}, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset("reset");

    launch("basic", 2, 0, 0);
    feed("basic_p0", 3, 0, 0, 1, 0);
    feed("basic_p1", 5, 0, 0, 3, 1);
    finish_job("basic", 0, 0);

    launch("zero", 0, 0, 0);
    finish_job("zero", 0, 0);

    launch("wrap8", 2, 0, 0);
    feed("wrap8_p0", 32'h0000_00FF, 0, 0, 1, 0);
    feed("wrap8_p1", 32'h0000_0002, 0, 0, 1, 1);
    finish_job("wrap8", 0, 1);

    launch("dtaint", 3, 0, 0);
    feed("dtaint_p0", 32'h11, 0, 0, 1, 0);
    feed("dtaint_p1", 32'h22, 1, 0, 2, 0);
    feed("dtaint_p2", 32'h33, 0, 0, 1, 1);
    finish_job("dtaint", 0, 0);
    launch("dclean", 1, 0, 0);
    feed("dclean_p0", 32'h44, 0, 0, 1, 1);
    finish_job("dclean", 0, 0);

    launch("wrap36", 20, 0, 0);
    for (int i = 0; i < 20; i++) feed("wrap36_p", 32'hFFFF_FFFF, 0, 0, 1, i == 19);
    finish_job("wrap36", 0, 0);

    for (int j = 0; j < 25; j++) begin
      n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      launch("rand", 8'(n), 0, 0);
      for (int i = 0; i < n; i++) begin
        feed("rand_p", $urandom, $urandom_range(0, 3) == 0, 0, $urandom_range(1, 3), i == n - 1);
        repeat ($urandom_range(0, 2)) tick();
      end
      finish_job("rand", 0, $urandom_range(0, 1));
    end

    // Each control-taint source in isolation; it must persist through a later clean run.
    for (int k = 0; k < 4; k++) begin
      do_reset("ctl_reset");
      launch("ctl", 2, k == 0, k == 1);
      feed("ctl_p0", $urandom, 0, k == 2, 1, 0);
      feed("ctl_p1", $urandom, 0, 0, 1, 1);
      finish_job("ctl", k == 3, 0);
      launch("ctl_clean", 1, 0, 0);
      feed("ctl_clean_p0", $urandom, 0, 0, 1, 1);
      finish_job("ctl_clean", 0, 0);
    end

    launch("abort", 3, 0, 0);
    feed("abort_p0", 32'h1234, 1, 1, 1, 0);
    rst = 1'b1;
    #1;
    exp_big = 0; exp_small = 0; ctl_m = 0; dat_m = 0;
    check_all("abort_rst", 0, 0);
    productDone = 1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check_all("abort_idle", 0, 0);
    launch("fresh", 1, 0, 0);
    tick();
    tick();
    check_all("fresh_held_done", 0, 1);
    productDone = 0;
    tick();
    feed("fresh_p0", 32'd7, 0, 0, 1, 1);
    finish_job("fresh", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
